// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: elaboration-time helpers for the serial pattern detector.
// Builds the KMP failure values and next-state transitions from (PATTERN, LEN).
package seq_detect_pkg;

    localparam int unsigned MAX_LEN = 16;

    // One KMP transition: hit marks a full-pattern completion, nxt the follow-on prefix length.
    typedef struct packed {
        logic       hit;
        logic [4:0] nxt;
    } step_t;

    // Width of the matched-prefix register; LEN >= 2 keeps this at least 1.
    function automatic int unsigned state_w(int unsigned len);
        return $clog2(len);
    endfunction

    // Pattern bit j in arrival order (j = 0 is the first bit received).
    function automatic logic pat_bit(logic [MAX_LEN-1:0] pattern, int unsigned len,
                                     int unsigned j);
        logic [3:0] pos;
        if (j >= len) return 1'b0;
        pos = 4'(len - 1 - j);
        return pattern[pos];
    endfunction

    // F(k): longest proper prefix of the first k pattern bits that is also their suffix.
    function automatic int unsigned failure(logic [MAX_LEN-1:0] pattern, int unsigned len,
                                            int unsigned k);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned l = 1; l < MAX_LEN; l++) begin
            if (l < k && k <= len) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < MAX_LEN; m++) begin
                    if (m < l && pat_bit(pattern, len, k - l + m) != pat_bit(pattern, len, m)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    // Transition from prefix length k on input bit b: the longest pattern prefix that is a
    // suffix of (prefix_k, b). A full-length result is a match and folds back to F(LEN) or 0.
    function automatic step_t next_state(logic [MAX_LEN-1:0] pattern, int unsigned len,
                                         bit overlap, int unsigned k, logic b);
        int unsigned best;
        int unsigned idx;
        logic        ok;
        logic        c;
        step_t       res;
        best = 0;
        for (int unsigned l = 1; l <= MAX_LEN; l++) begin
            if (l <= k + 1 && l <= len) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < MAX_LEN; m++) begin
                    if (m < l) begin
                        idx = k + 1 - l + m;
                        c   = (idx < k) ? pat_bit(pattern, len, idx) : b;
                        if (c != pat_bit(pattern, len, m)) ok = 1'b0;
                    end
                end
                if (ok) best = l;
            end
        end
        res.hit = (best == len);
        if (res.hit) begin
            res.nxt = overlap ? 5'(failure(pattern, len, len)) : 5'd0;
        end else begin
            res.nxt = 5'(best);
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detect_if.sv
// seq_detect_if: serial data/strobe inputs and match/debug outputs of the detector.
interface seq_detect_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned LEN   = 5,
    parameter int unsigned CNT_W = 8
);
    logic                    i;
    logic                    i_valid;
    logic                    cnt_clr;
    logic                    out;
    logic [state_w(LEN)-1:0] state;
    logic [CNT_W-1:0]        match_count;

    modport master (output i, i_valid, cnt_clr, input out, state, match_count);
    modport slave  (input i, i_valid, cnt_clr, output out, state, match_count);
endinterface

// File: rtl/seq_detect_cnt.sv
// seq_detect_cnt: saturating match counter; clear takes priority over increment.
module seq_detect_cnt
    import seq_detect_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && count_q != '1) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/seq_detect.sv
// seq_detect: parametrised serial pattern detector (KMP automaton, registered match pulse).
// Define SEQ_DETECT_COUNT_EN to build the saturating match counter; otherwise match_count is 0
// and cnt_clr is ignored.
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter int unsigned        LEN     = 5,        // 2..16
    parameter logic [MAX_LEN-1:0] PATTERN = 16'b11011,
    parameter int unsigned        OVERLAP = 1,
    parameter int unsigned        CNT_W   = 8
) (
    input logic         clk,
    input logic         rst,
    seq_detect_if.slave bus
);
    localparam int unsigned SW     = state_w(LEN);
    localparam int unsigned NumIdx = 2 ** (SW + 1);

    // Transition tables indexed by {state, bit}; entries for unreachable states are zero.
    logic [NumIdx-1:0][SW-1:0] nxt_tbl;
    logic [NumIdx-1:0]         hit_tbl;

    for (genvar idx = 0; idx < NumIdx; idx++) begin : g_tbl
        localparam int unsigned S = idx / 2;
        localparam int unsigned B = idx % 2;
        if (S < LEN) begin : g_live
            localparam step_t Step = next_state(PATTERN, LEN, OVERLAP != 0, S, B == 1);
            assign nxt_tbl[idx] = SW'(Step.nxt);
            assign hit_tbl[idx] = Step.hit;
        end else begin : g_dead
            assign nxt_tbl[idx] = '0;
            assign hit_tbl[idx] = 1'b0;
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic          out_q, out_d;
    logic          hit;

    // Advance the automaton on qualified bits only; the pulse is a single cycle.
    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        hit     = 1'b0;
        if (bus.i_valid) begin
            state_d = nxt_tbl[{state_q, bus.i}];
            hit     = hit_tbl[{state_q, bus.i}];
            out_d   = hit;
        end
    end

    // Prefix-length and pulse registers; reset discards any partial match.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.state = state_q;
    assign bus.out   = out_q;

`ifdef SEQ_DETECT_COUNT_EN
    seq_detect_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.cnt_clr),
        .inc  (hit),
        .count(bus.match_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/seq_detect.md
# seq_detect

Parametrised serial bit-pattern detector. It is the generalised successor to the fixed five-bit "11011" detector, with the pattern, its length and the overlap mode set at elaboration. It adds a qualifying valid strobe, a synchronous reset and an optional saturating match counter. It sits on serial control/framing lines and raises a one-cycle registered pulse each time the pattern completes.

## Interface
Parameters:
- LEN, 5, pattern length in bits; legal range 2..16.
- PATTERN, 16'b11011, pattern value; low LEN bits are used; bit LEN-1 is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i  in  1  serial data bit.
- i_valid  in  1  qualifies i; when low, the bit is ignored.
- cnt_clr  in  1  synchronous clear of match_count.
- out  out  1  registered match pulse.
- state  out  $clog2(LEN)  matched-prefix length, for debug.
- match_count  out  CNT_W  saturating number of matches.

## Operation
- state = length of the longest pattern prefix that is a suffix of the valid bits received so far; range 0..LEN-1.
- On each clk edge with i_valid=1, the candidate string is the current prefix followed by i:
  - If the candidate equals the full pattern: out<=1 and the match counter increments. Next state is OVERLAP ? F(LEN) : 0, where F(k) = longest proper prefix of the first k pattern bits that is also their suffix.
  - Otherwise: out<=0 and the next state is the longest pattern prefix that is a suffix of the candidate (KMP transition).
- i_valid=0: state holds, out<=0, count holds.
- Transition table and failure values are computed at elaboration from PATTERN; no runtime pattern load.
- Counter: increments on a match and saturates at 2^CNT_W-1. cnt_clr sets it to 0. If cnt_clr and a match occur in the same cycle, clear wins and that match is not counted. cnt_clr does not affect state or out.
- Reset: state=0, out=0, match_count=0. Reset dominates i_valid and cnt_clr. Reset mid-pattern discards the partial match.

## Timing
- out and match_count update on the edge that samples the completing bit; visible the following cycle; latency 1 clk.
- out is high for exactly one cycle per match. Back-to-back pulses are possible only when OVERLAP=1 and F(LEN)=LEN-1 (e.g. all-ones pattern).
- No combinational path from any input to any output.

## Configuration
- SEQ_DETECT_COUNT_EN defined: match counter and cnt_clr logic are built as described.
- Not defined: the counter is removed, match_count is tied to 0, cnt_clr is ignored, and out/state behaviour is unchanged.

## Structure
- Package seq_detect_pkg holds:
  - the function computing the failure values F(k) from (PATTERN, LEN);
  - the next-state function;
  - the state-width helper;
  - localparam MAX_LEN=16.
- Sub-module seq_detect_cnt: saturating counter with clr and inc inputs. Instantiated only under SEQ_DETECT_COUNT_EN.

## Test plan
All scenarios use PATTERN=11011, LEN=5, with i_valid=1 unless stated.
- OVERLAP=1, stream 1,1,0,1,1,0,1,1 -> out pulses the cycle after bit 5 and after bit 8; match_count=2; state=2 after bit 8.
- OVERLAP=0, same stream -> single pulse after bit 5; state=2 after bit 8; match_count=1.
- Stream 1,1,1,0,1,1 -> state sequence 1,2,2,3,4; single pulse after bit 6.
- Stream 1,1, then i_valid=0 for 3 cycles with i toggling, then 0,1,1 -> state holds at 2 during the gap; one pulse after the final bit.
- Stream 1,1,0,1, then rst for 1 cycle, then 1 -> no pulse; state=1 after the final bit; match_count=0.
- CNT_W=2, five separate matches -> match_count stays at 3. Then cnt_clr asserted on the edge of a sixth completing bit -> out pulses and match_count=0.
